// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared encodings for the MIPS-lite execute stage: ALU select
//               codes, R-type funct[3:0] codes and ALUOp codes.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALU select codes (gout)
    localparam logic [2:0] ALU_AND   = 3'b000;
    localparam logic [2:0] ALU_OR    = 3'b001;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_PASSA = 3'b011;
    localparam logic [2:0] ALU_SUB   = 3'b110;
    localparam logic [2:0] ALU_SLT   = 3'b111;

    // R-type funct[3:0] codes
    localparam logic [3:0] FN_ADD    = 4'b0000;
    localparam logic [3:0] FN_SUB    = 4'b0010;
    localparam logic [3:0] FN_AND    = 4'b0100;
    localparam logic [3:0] FN_OR     = 4'b0101;
    localparam logic [3:0] FN_SLT    = 4'b1010;
    localparam logic [3:0] FN_BALRZ  = 4'b0110;

    // ALUOp codes; R-type is recognised by bit 1 alone (1x)
    localparam logic [1:0] AOP_ADD   = 2'b00;
    localparam logic [1:0] AOP_SUB   = 2'b01;
    localparam logic [1:0] AOP_RTYPE = 2'b10;

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_dec.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_dec
// Description : ALU-control decode. Maps ALUOp and funct[3:0] to the 3-bit
//               ALU select and the balrz indication. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic       aluop1,
    input  logic       aluop0,
    input  logic [3:0] funct,
    output logic [2:0] gout,
    output logic       balrz
);

    // Decode ALUOp first; funct only matters for R-type (aluop1 set)
    always_comb begin
        gout  = ALU_ADD;
        balrz = 1'b0;
        if (aluop1) begin
            case (funct)
                FN_ADD:   gout = ALU_ADD;
                FN_SUB:   gout = ALU_SUB;
                FN_AND:   gout = ALU_AND;
                FN_OR:    gout = ALU_OR;
                FN_SLT:   gout = ALU_SLT;
                FN_BALRZ: begin
                    gout  = ALU_PASSA;
                    balrz = 1'b1;
                end
                default:  gout = ALU_ADD;
            endcase
        end else if (aluop0) begin
            gout = ALU_SUB;
        end else begin
            gout = ALU_ADD;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : Execute-stage datapath of the single-cycle MIPS-lite core:
//               ALU-control decode, 32-bit ALU, PC+4 adder, branch-target
//               adder and a registered zero flag for next-cycle PC select.
//               Optional macro ALU_OVF_EN adds the signed-overflow port ovf.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        aluop1,
    input  logic        aluop0,
    input  logic [3:0]  funct,
    input  logic [31:0] pc,
    input  logic [31:0] br_off,
    output logic [31:0] result,
    output logic        zout,
    output logic        zero_q,
    output logic [2:0]  gout,
    output logic        balrz,
    output logic [31:0] pc_plus4,
    output logic [31:0] br_target
`ifdef ALU_OVF_EN
    ,
    output logic        ovf
`endif
);

    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic        w_slt;

    alu_ctrl_dec u_dec (
        .aluop1 (aluop1),
        .aluop0 (aluop0),
        .funct  (funct),
        .gout   (gout),
        .balrz  (balrz)
    );

    // Shared arithmetic; both wrap modulo 2^32 with carry dropped
    always_comb begin
        w_sum  = a + b;
        w_diff = a - b;
        w_slt  = ($signed(a) < $signed(b));
    end

    // ALU result mux; unused select codes (100/101) force a defined zero
    always_comb begin
        result = 32'd0;
        case (gout)
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_ADD:   result = w_sum;
            ALU_SUB:   result = w_diff;
            ALU_SLT:   result = {31'd0, w_slt};
            ALU_PASSA: result = a;
            default:   result = 32'd0;
        endcase
    end

    // Zero detect and the PC adders
    always_comb begin
        zout      = (result == 32'd0);
        pc_plus4  = pc + 32'd4;
        br_target = pc_plus4 + br_off;
    end

`ifdef ALU_OVF_EN
    // Signed overflow: operands' signs agree (add) or differ (sub) and the
    // result sign departs from a
    always_comb begin
        ovf = 1'b0;
        case (gout)
            ALU_ADD: ovf = (a[31] == b[31]) && (w_sum[31]  != a[31]);
            ALU_SUB: ovf = (a[31] != b[31]) && (w_diff[31] != a[31]);
            default: ovf = 1'b0;
        endcase
    end
`endif

    // Registered zero flag consumed by next-cycle balrz/PC selection
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zout;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_unit
// Description : Directed self-checking bench for alu_exec_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        aluop1;
    logic        aluop0;
    logic [3:0]  funct;
    logic [31:0] pc;
    logic [31:0] br_off;
    logic [31:0] result;
    logic        zout;
    logic        zero_q;
    logic [2:0]  gout;
    logic        balrz;
    logic [31:0] pc_plus4;
    logic [31:0] br_target;
`ifdef ALU_OVF_EN
    logic        ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    alu_exec_unit dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .aluop1    (aluop1),
        .aluop0    (aluop0),
        .funct     (funct),
        .pc        (pc),
        .br_off    (br_off),
        .result    (result),
        .zout      (zout),
        .zero_q    (zero_q),
        .gout      (gout),
        .balrz     (balrz),
        .pc_plus4  (pc_plus4),
        .br_target (br_target)
`ifdef ALU_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply an operation just after a rising edge and let it settle
    task automatic apply(input logic [1:0] aop, input logic [3:0] fn,
                         input logic [31:0] va, input logic [31:0] vb);
        @(posedge clk);
        #1;
        aluop1 = aop[1];
        aluop0 = aop[0];
        funct  = fn;
        a      = va;
        b      = vb;
        #1;
    endtask

    initial begin
        rst = 1'b1; a = 32'd0; b = 32'd0; aluop1 = 1'b0; aluop0 = 1'b0;
        funct = 4'd0; pc = 32'd0; br_off = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_zero_q", {31'd0, zero_q}, 32'd0);
        rst = 1'b0;

        // add: 5+3
        apply(2'b00, 4'b0000, 32'd5, 32'd3);
        chk("add_gout",   {29'd0, gout}, 32'd2);
        chk("add_result", result, 32'd8);
        chk("add_zout",   {31'd0, zout}, 32'd0);
        chk("add_balrz",  {31'd0, balrz}, 32'd0);
        @(posedge clk); #1;
        chk("add_zero_q", {31'd0, zero_q}, 32'd0);

        // sub: 7-7, balrz funct must be ignored when aluop1=0
        apply(2'b01, 4'b0110, 32'd7, 32'd7);
        chk("sub_gout",   {29'd0, gout}, 32'd6);
        chk("sub_result", result, 32'd0);
        chk("sub_zout",   {31'd0, zout}, 32'd1);
        chk("sub_balrz",  {31'd0, balrz}, 32'd0);
        @(posedge clk); #1;
        chk("sub_zero_q", {31'd0, zero_q}, 32'd1);

        // reset mid-operation clears only zero_q
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_zero_q",  {31'd0, zero_q}, 32'd0);
        chk("rst_result",  result, 32'd0);
        chk("rst_zout",    {31'd0, zout}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_zero_q", {31'd0, zero_q}, 32'd1);

        // sub wrap: 0-1
        apply(2'b01, 4'b0000, 32'd0, 32'd1);
        chk("sub_wrap", result, 32'hFFFF_FFFF);

        // add wrap: FFFFFFFF+1, carry dropped
        apply(2'b00, 4'b0000, 32'hFFFF_FFFF, 32'd1);
        chk("add_wrap", result, 32'd0);
        chk("add_wrap_zout", {31'd0, zout}, 32'd1);

        // slt: -1 < 1 signed
        apply(2'b10, 4'b1010, 32'hFFFF_FFFF, 32'd1);
        chk("slt_gout",   {29'd0, gout}, 32'd7);
        chk("slt_result", result, 32'd1);
        apply(2'b10, 4'b1010, 32'd1, 32'hFFFF_FFFF);
        chk("slt_false",  result, 32'd0);

        // and/or
        apply(2'b10, 4'b0100, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        chk("and_gout",   {29'd0, gout}, 32'd0);
        chk("and_result", result, 32'h00F0_00F0);
        apply(2'b10, 4'b0101, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        chk("or_gout",    {29'd0, gout}, 32'd1);
        chk("or_result",  result, 32'hFFF0_FFF0);

        // R-type add/sub, aluop=11 also R-type
        apply(2'b11, 4'b0010, 32'd10, 32'd3);
        chk("rsub_gout",   {29'd0, gout}, 32'd6);
        chk("rsub_result", result, 32'd7);
        apply(2'b10, 4'b0000, 32'd10, 32'd3);
        chk("radd_result", result, 32'd13);

        // unknown funct falls back to add
        apply(2'b10, 4'b1111, 32'd2, 32'd2);
        chk("unk_gout",   {29'd0, gout}, 32'd2);
        chk("unk_balrz",  {31'd0, balrz}, 32'd0);
        chk("unk_result", result, 32'd4);

        // balrz passes a
        apply(2'b10, 4'b0110, 32'd0, 32'd9);
        chk("balrz_flag", {31'd0, balrz}, 32'd1);
        chk("balrz_gout", {29'd0, gout}, 32'd3);
        chk("balrz_zout0", {31'd0, zout}, 32'd1);
        apply(2'b10, 4'b0110, 32'd4, 32'd0);
        chk("balrz_result", result, 32'd4);
        chk("balrz_zout1",  {31'd0, zout}, 32'd0);

        // PC adders
        pc = 32'hFFFF_FFFC; br_off = 32'd8; #1;
        chk("pc4_wrap",  pc_plus4, 32'd0);
        chk("brt_wrap",  br_target, 32'd8);
        pc = 32'h0000_0100; br_off = 32'hFFFF_FFF0; #1;
        chk("pc4",       pc_plus4, 32'h0000_0104);
        chk("brt_neg",   br_target, 32'h0000_00F4);

`ifdef ALU_OVF_EN
        apply(2'b00, 4'b0000, 32'h7FFF_FFFF, 32'd1);
        chk("ovf_add",    {31'd0, ovf}, 32'd1);
        apply(2'b01, 4'b0000, 32'h8000_0000, 32'd1);
        chk("ovf_sub",    {31'd0, ovf}, 32'd1);
        apply(2'b00, 4'b0000, 32'd5, 32'd3);
        chk("ovf_none",   {31'd0, ovf}, 32'd0);
        apply(2'b10, 4'b0101, 32'h7FFF_FFFF, 32'd1);
        chk("ovf_or",     {31'd0, ovf}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
